// File: rtl/mstream_fifo_if.sv
// Handshake bundle for mstream_fifo: ingress/egress streams of NUM_ROWS-row beats plus flush and fill level.
// The in_beats/out_beats counters exist only when MSTREAM_FIFO_STATS_EN is defined.
interface mstream_fifo_if #(
    parameter int NUM_ROWS   = 3,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
);
    localparam int BEAT_W = NUM_ROWS * DATA_WIDTH;
    localparam int LVL_W  = $clog2(DEPTH + 1);

    logic              ig_vld;
    logic              ig_rdy;
    logic [BEAT_W-1:0] ig_data;
    logic              eg_vld;
    logic              eg_rdy;
    logic [BEAT_W-1:0] eg_data;
    logic              flush;
    logic [LVL_W-1:0]  level;
`ifdef MSTREAM_FIFO_STATS_EN
    logic [31:0]       in_beats;
    logic [31:0]       out_beats;
`endif

    modport slave (
        input  ig_vld, ig_data, eg_rdy, flush,
        output ig_rdy, eg_vld, eg_data, level
`ifdef MSTREAM_FIFO_STATS_EN
        , output in_beats, out_beats
`endif
    );

    modport master (
        output ig_vld, ig_data, eg_rdy, flush,
        input  ig_rdy, eg_vld, eg_data, level
`ifdef MSTREAM_FIFO_STATS_EN
        , input in_beats, out_beats
`endif
    );
endinterface

// File: rtl/mstream_fifo.sv
// First-word-fall-through FIFO of multi-row beats with registered ready/valid and synchronous flush.
// Optional transfer counters are compiled in by defining MSTREAM_FIFO_STATS_EN.
module mstream_fifo #(
    parameter int NUM_ROWS   = 3,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    mstream_fifo_if.slave  bus
);
    localparam int BEAT_W = NUM_ROWS * DATA_WIDTH;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = $clog2(DEPTH + 1);

    logic [BEAT_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  level_r;
    logic [LVL_W-1:0]  level_nxt_s;
    logic              ig_rdy_r;
    logic              eg_vld_r;
    logic              push_s;
    logic              pop_s;

    assign push_s = bus.ig_vld && ig_rdy_r;
    assign pop_s  = eg_vld_r && bus.eg_rdy;

    // Next fill level from the push/pop pair; simultaneous transfers cancel out.
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_W'(1);
            2'b01:   level_nxt_s = level_r - LVL_W'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Control state; flush wins over any transfer on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            level_r  <= LVL_W'(0);
            ig_rdy_r <= 1'b0;
            eg_vld_r <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            level_r  <= LVL_W'(0);
            ig_rdy_r <= 1'b1;
            eg_vld_r <= 1'b0;
        end else begin
            // DEPTH is a power of two, so the natural pointer rollover is the wrap.
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            level_r  <= level_nxt_s;
            ig_rdy_r <= (level_nxt_s != LVL_W'(DEPTH));
            eg_vld_r <= (level_nxt_s != LVL_W'(0));
        end
    end

    // Beat storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s && !bus.flush) begin
            mem_r[wr_ptr_r] <= bus.ig_data;
        end
    end

    assign bus.ig_rdy  = ig_rdy_r;
    assign bus.eg_vld  = eg_vld_r;
    assign bus.eg_data = mem_r[rd_ptr_r];
    assign bus.level   = level_r;

`ifdef MSTREAM_FIFO_STATS_EN
    logic [31:0] in_beats_r;
    logic [31:0] out_beats_r;

    // Transfer counters survive flush and count only transfers that flush did not discard.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_beats_r  <= 32'd0;
            out_beats_r <= 32'd0;
        end else begin
            if (push_s && !bus.flush) begin
                in_beats_r <= in_beats_r + 32'd1;
            end else begin
                in_beats_r <= in_beats_r;
            end
            if (pop_s && !bus.flush) begin
                out_beats_r <= out_beats_r + 32'd1;
            end else begin
                out_beats_r <= out_beats_r;
            end
        end
    end

    assign bus.in_beats  = in_beats_r;
    assign bus.out_beats = out_beats_r;
`endif
endmodule

// File: tb/tb_mstream_fifo.sv
// Scoreboard bench for mstream_fifo (NUM_ROWS=3, DATA_WIDTH=32, DEPTH=8); stats checks when MSTREAM_FIFO_STATS_EN is defined.
module tb_mstream_fifo;
    localparam int NR = 3;
    localparam int DW = 32;
    localparam int DP = 8;
    localparam int BW = NR * DW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [BW-1:0] exp_q [$];

    mstream_fifo_if #(.NUM_ROWS(NR), .DATA_WIDTH(DW), .DEPTH(DP)) bus ();

    mstream_fifo #(.NUM_ROWS(NR), .DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard: record accepted beats, compare every beat that leaves.
    always @(negedge clk) begin
        logic [BW-1:0] exp_d;
        if (!reset_n || bus.flush) begin
            exp_q.delete();
        end else begin
            if (bus.eg_vld && bus.eg_rdy) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_pop: got beat %h, required no beat", bus.eg_data);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (bus.eg_data !== exp_d) begin
                        n_err++;
                        $display("FAIL sb_data: got %h, required %h", bus.eg_data, exp_d);
                    end
                end
            end
            if (bus.ig_vld && bus.ig_rdy) exp_q.push_back(bus.ig_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] rnd_beat();
        return {$urandom, $urandom, $urandom};
    endfunction

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            bus.ig_vld  = 1'b1;
            bus.ig_data = rnd_beat();
            tick();
        end
        bus.ig_vld = 1'b0;
    endtask

    task automatic drain(output bit ok);
        int c = 0;
        bus.ig_vld = 1'b0;
        bus.eg_rdy = 1'b1;
        while (bus.eg_vld && c < 40) begin
            tick();
            c++;
        end
        bus.eg_rdy = 1'b0;
        ok = !bus.eg_vld;
    endtask

    task automatic test_reset();
        bus.ig_vld = 1'b0; bus.eg_rdy = 1'b0; bus.flush = 1'b0; bus.ig_data = '0;
        reset_n = 1'b0;
        #23;
        n_vec++;
        if (bus.eg_vld !== 1'b0 || bus.ig_rdy !== 1'b0 || bus.level !== 4'd0) begin
            n_err++;
            $display("FAIL rst_state: vld=%b rdy=%b lvl=%0d, required 0 0 0", bus.eg_vld, bus.ig_rdy, bus.level);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        n_vec++;
        if (bus.ig_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL rst_release_rdy: got %b, required 1", bus.ig_rdy);
        end
    endtask

    task automatic test_single();
        logic [BW-1:0] d;
        d = {32'h3, 32'h2, 32'h1};
        bus.eg_rdy = 1'b1;
        bus.ig_vld = 1'b1;
        bus.ig_data = d;
        tick();
        bus.ig_vld = 1'b0;
        bus.ig_data = rnd_beat();
        n_vec++;
        if (bus.eg_vld !== 1'b1 || bus.eg_data !== d) begin
            n_err++;
            $display("FAIL single_out: vld=%b data=%h, required 1 %h", bus.eg_vld, bus.eg_data, d);
        end
        tick();
        n_vec++;
        if (bus.level !== 4'd0 || bus.eg_vld !== 1'b0) begin
            n_err++;
            $display("FAIL single_empty: lvl=%0d vld=%b, required 0 0", bus.level, bus.eg_vld);
        end
        bus.eg_rdy = 1'b0;
    endtask

    task automatic test_fill();
        bit ok;
        bus.eg_rdy = 1'b0;
        fill(DP);
        n_vec++;
        if (bus.level !== 4'd8 || bus.ig_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL fill_full: lvl=%0d rdy=%b, required 8 0", bus.level, bus.ig_rdy);
        end
        bus.ig_vld = 1'b1;
        bus.ig_data = rnd_beat();
        tick();
        bus.ig_vld = 1'b0;
        n_vec++;
        if (bus.level !== 4'd8) begin
            n_err++;
            $display("FAIL fill_overflow: lvl=%0d, required 8", bus.level);
        end
        bus.eg_rdy = 1'b1;
        tick();
        n_vec++;
        if (bus.ig_rdy !== 1'b1 || bus.level !== 4'd7) begin
            n_err++;
            $display("FAIL fill_first_pop: rdy=%b lvl=%0d, required 1 7", bus.ig_rdy, bus.level);
        end
        drain(ok);
        n_vec++;
        if (!ok || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL fill_drain: ok=%0d left=%0d, required 1 0", ok, exp_q.size());
        end
    endtask

    task automatic test_concurrent();
        int mdl_lvl;
        bit push, pop, stalled, ok;
        logic [BW-1:0] held;
        bus.eg_rdy = 1'b0;
        fill(4);
        mdl_lvl = 4;
        for (int i = 0; i < 40; i++) begin
            bus.ig_vld  = ($urandom_range(0, 3) != 0);
            bus.ig_data = rnd_beat();
            bus.eg_rdy  = $urandom_range(0, 1);
            #1;
            push = bus.ig_vld && (mdl_lvl != DP);
            pop  = bus.eg_rdy && (mdl_lvl != 0);
            stalled = (mdl_lvl != 0) && !bus.eg_rdy;
            held = bus.eg_data;
            tick();
            mdl_lvl = mdl_lvl + int'(push) - int'(pop);
            n_vec++;
            if (int'(bus.level) != mdl_lvl || bus.ig_rdy !== (mdl_lvl != DP) || bus.eg_vld !== (mdl_lvl != 0)) begin
                n_err++;
                $display("FAIL conc_level: lvl=%0d rdy=%b vld=%b, required lvl %0d", bus.level, bus.ig_rdy, bus.eg_vld, mdl_lvl);
            end
            if (stalled) begin
                n_vec++;
                if (bus.eg_vld !== 1'b1 || bus.eg_data !== held) begin
                    n_err++;
                    $display("FAIL conc_stall: vld=%b data=%h, required 1 %h", bus.eg_vld, bus.eg_data, held);
                end
            end
        end
        drain(ok);
        n_vec++;
        if (!ok || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL conc_drain: ok=%0d left=%0d, required 1 0", ok, exp_q.size());
        end
    endtask

    task automatic test_flush();
`ifdef MSTREAM_FIFO_STATS_EN
        logic [31:0] ib, ob;
`endif
        bus.eg_rdy = 1'b0;
        fill(5);
`ifdef MSTREAM_FIFO_STATS_EN
        ib = bus.in_beats;
        ob = bus.out_beats;
`endif
        bus.ig_vld = 1'b1;
        bus.ig_data = rnd_beat();
        bus.eg_rdy = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.ig_vld = 1'b0;
        n_vec++;
        if (bus.level !== 4'd0 || bus.eg_vld !== 1'b0 || bus.ig_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL flush_state: lvl=%0d vld=%b rdy=%b, required 0 0 1", bus.level, bus.eg_vld, bus.ig_rdy);
        end
        tick();
        tick();
        n_vec++;
        if (bus.eg_vld !== 1'b0) begin
            n_err++;
            $display("FAIL flush_stale: vld=%b, required 0", bus.eg_vld);
        end
`ifdef MSTREAM_FIFO_STATS_EN
        n_vec++;
        if (bus.in_beats !== ib || bus.out_beats !== ob) begin
            n_err++;
            $display("FAIL flush_stats: in=%0d out=%0d, required %0d %0d", bus.in_beats, bus.out_beats, ib, ob);
        end
`endif
        bus.eg_rdy = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.eg_rdy = 1'b0;
        fill(3);
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (bus.eg_vld !== 1'b0 || bus.ig_rdy !== 1'b0 || bus.level !== 4'd0) begin
            n_err++;
            $display("FAIL rstmid_state: vld=%b rdy=%b lvl=%0d, required 0 0 0", bus.eg_vld, bus.ig_rdy, bus.level);
        end
        tick();
        reset_n = 1'b1;
        tick();
        n_vec++;
        if (bus.ig_rdy !== 1'b1 || bus.eg_vld !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_release: rdy=%b vld=%b, required 1 0", bus.ig_rdy, bus.eg_vld);
        end
        bus.eg_rdy = 1'b1;
        tick();
        tick();
        n_vec++;
        if (bus.eg_vld !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_stale: vld=%b, required 0", bus.eg_vld);
        end
`ifdef MSTREAM_FIFO_STATS_EN
        n_vec++;
        if (bus.in_beats !== 32'd0 || bus.out_beats !== 32'd0) begin
            n_err++;
            $display("FAIL rstmid_stats: in=%0d out=%0d, required 0 0", bus.in_beats, bus.out_beats);
        end
`endif
        bus.eg_rdy = 1'b0;
    endtask

    task automatic test_counts();
        int pushes = 0;
        int pops = 0;
        int c = 0;
        bit ok;
        while ((pushes < 100 || pops < 97) && c < 600) begin
            bus.ig_vld  = (pushes < 100) && ($urandom_range(0, 3) != 0);
            bus.ig_data = rnd_beat();
            bus.eg_rdy  = (pops < 97) && ($urandom_range(0, 2) != 0);
            #1;
            if (bus.ig_vld && bus.ig_rdy) pushes++;
            if (bus.eg_vld && bus.eg_rdy) pops++;
            tick();
            c++;
        end
        bus.ig_vld = 1'b0;
        bus.eg_rdy = 1'b0;
        n_vec++;
        if (c >= 600 || bus.level !== 4'd3) begin
            n_err++;
            $display("FAIL counts_level: lvl=%0d cycles=%0d, required 3 within 600", bus.level, c);
        end
`ifdef MSTREAM_FIFO_STATS_EN
        n_vec++;
        if (bus.in_beats !== 32'd100 || bus.out_beats !== 32'd97) begin
            n_err++;
            $display("FAIL counts_stats: in=%0d out=%0d, required 100 97", bus.in_beats, bus.out_beats);
        end
`endif
        drain(ok);
        n_vec++;
        if (!ok || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL counts_drain: ok=%0d left=%0d, required 1 0", ok, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_concurrent();
        test_flush();
        test_reset_mid();
        test_counts();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
